// File: rtl/pla_tt_capture.sv
// -----------------------------------------------------------------------------
// pla_tt_capture
//
// Purpose:
//   Sequential stimulus/capture engine for a single-output combinational PLA
//   with N_IN inputs. It walks x_out through every input vector 0 .. 2**N_IN-1.
//   Each vector is held for SETTLE+1 cycles. y_in is sampled on the last edge
//   of that window, and the sample is written into the truth-table register tt.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   single-cycle sweep request, accepted only when idle
//   x_out      out  [N_IN]     vector driven to the function under test
//   y_in       in   function output for the current x_out
//   busy       out  high while a sweep is in progress
//   done       out  one-cycle pulse; tt is complete and stable from this cycle
//   tt         out  [2**N_IN]  captured truth table, bit k = y0 for x = k
//
// Optional compare feature, enabled by the macro PLA_TT_COMPARE_EN:
//   tt_ref     in   [2**N_IN]  golden table, held stable during a sweep
//   mismatch   out  mism_cnt != 0, valid from the done cycle
//   mism_cnt   out  [N_IN+1]   number of sampled bits differing from tt_ref
//   first_mism out  [N_IN]     lowest differing index (0 if none)
//
// Parameters:
//   N_IN    number of function inputs
//   SETTLE  extra hold cycles per vector before sampling (0..15)
// -----------------------------------------------------------------------------
module pla_tt_capture #(
    parameter int unsigned N_IN   = 6,
    parameter int unsigned SETTLE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [N_IN-1:0]      x_out,
    input  logic                 y_in,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   tt
`ifdef PLA_TT_COMPARE_EN
    ,
    input  logic [2**N_IN-1:0]   tt_ref,
    output logic                 mismatch,
    output logic [N_IN:0]        mism_cnt,
    output logic [N_IN-1:0]      first_mism
`endif
);

    localparam int unsigned     TT_W     = 2**N_IN;
    localparam logic [N_IN-1:0] X_LAST   = '1;
    localparam logic [N_IN-1:0] X_ONE    = 1;
    localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
    localparam logic [3:0]      HOLD_ONE = 4'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        FIN   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   x_out_q, x_out_d;
    logic [3:0]        hold_q,  hold_d;
    logic [TT_W-1:0]   tt_q,    tt_d;

    logic              sample;
    logic              last_vec;
    logic              accept;

    // A vector is sampled on the final edge of its SETTLE+1 cycle window.
    assign sample   = (state_q == SWEEP) && (hold_q == SETTLE_C);
    assign last_vec = (x_out_q == X_LAST);
    assign accept   = (state_q == IDLE) && start;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (sample && last_vec) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (decoded from the registered state, so glitch-free)
    // -------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            SWEEP:   busy = 1'b1;
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: vector counter, hold counter, truth table
    // -------------------------------------------------------------------------
    always_comb begin
        x_out_d = x_out_q;
        hold_d  = hold_q;
        tt_d    = tt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_out_d = '0;
                    hold_d  = '0;
                    tt_d    = '0;
                end
            end
            SWEEP: begin
                if (sample) begin
                    tt_d[x_out_q] = y_in;
                    // x_out stays on the last vector until FIN, never wraps.
                    if (!last_vec) begin
                        x_out_d = x_out_q + X_ONE;
                        hold_d  = '0;
                    end
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            FIN: begin
                x_out_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_out_q <= '0;
            hold_q  <= '0;
            tt_q    <= '0;
        end else begin
            x_out_q <= x_out_d;
            hold_q  <= hold_d;
            tt_q    <= tt_d;
        end
    end

    assign x_out = x_out_q;
    assign tt    = tt_q;

`ifdef PLA_TT_COMPARE_EN
    // -------------------------------------------------------------------------
    // Optional compare against a golden table
    // -------------------------------------------------------------------------
    localparam logic [N_IN:0] CNT_ONE = 1;

    logic [N_IN:0]   mism_cnt_q,   mism_cnt_d;
    logic [N_IN-1:0] first_mism_q, first_mism_d;

    always_comb begin
        mism_cnt_d   = mism_cnt_q;
        first_mism_d = first_mism_q;
        if (accept) begin
            mism_cnt_d   = '0;
            first_mism_d = '0;
        end else if (sample && (y_in != tt_ref[x_out_q])) begin
            mism_cnt_d = mism_cnt_q + CNT_ONE;
            // Vectors are visited in ascending order, so the first
            // difference seen is the lowest differing index.
            if (mism_cnt_q == '0) begin
                first_mism_d = x_out_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mism_cnt_q   <= '0;
            first_mism_q <= '0;
        end else begin
            mism_cnt_q   <= mism_cnt_d;
            first_mism_q <= first_mism_d;
        end
    end

    assign mism_cnt   = mism_cnt_q;
    assign first_mism = first_mism_q;
    assign mismatch   = (mism_cnt_q != '0);
`endif

endmodule

// File: tb/tb_pla_tt_capture.sv
module tb_pla_tt_capture;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, start2;
    logic [5:0]  x_out, x_out2;
    logic        y_in, y_in2;
    logic        busy, done, busy2, done2;
    logic [63:0] tt, tt2;
`ifdef PLA_TT_COMPARE_EN
    logic [63:0] tt_ref, tt_ref2;
    logic        mismatch, mismatch2;
    logic [6:0]  mism_cnt, mism_cnt2;
    logic [5:0]  first_mism, first_mism2;
`endif

    // Function under test for the SETTLE=0 instance.
    int fn_sel;
    always_comb begin
        case (fn_sel)
            1:       y_in = x_out[0];
            2:       y_in = &x_out;
            default: y_in = 1'b0;
        endcase
    end

    // Registered two-stage path for the SETTLE=2 instance: y0 = x5, two cycles late.
    logic [1:0] y2_pipe;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) y2_pipe <= '0;
        else        y2_pipe <= {y2_pipe[0], x_out2[5]};
    end
    assign y_in2 = y2_pipe[1];

    pla_tt_capture #(.N_IN(6), .SETTLE(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_out(x_out), .y_in(y_in),
        .busy(busy), .done(done), .tt(tt)
`ifdef PLA_TT_COMPARE_EN
        , .tt_ref(tt_ref), .mismatch(mismatch), .mism_cnt(mism_cnt), .first_mism(first_mism)
`endif
    );

    pla_tt_capture #(.N_IN(6), .SETTLE(2)) u_dut_s2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .x_out(x_out2), .y_in(y_in2),
        .busy(busy2), .done(done2), .tt(tt2)
`ifdef PLA_TT_COMPARE_EN
        , .tt_ref(tt_ref2), .mismatch(mismatch2), .mism_cnt(mism_cnt2), .first_mism(first_mism2)
`endif
    );

    typedef struct {
        logic [63:0] tt;
        int          lat;
        logic [6:0]  cnt;
        logic [5:0]  first;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Edges are counted with the start edge as edge 1. Called at a negedge.
    task automatic sweep0(input int fn, input logic [63:0] exp_tt, input logic [63:0] ref_tt,
                          input logic [6:0] exp_cnt, input logic [5:0] exp_first,
                          input int poke_at, input bit poke_fin);
        exp_t e;
        int   edges;
        int   busy_cnt;
        fn_sel = fn;
`ifdef PLA_TT_COMPARE_EN
        tt_ref = ref_tt;
`else
        if (ref_tt != exp_tt) fn_sel = fn;
`endif
        e.tt = exp_tt; e.lat = 65; e.cnt = exp_cnt; e.first = exp_first;
        sb_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        check_eq("busy_rise", busy, 1);
        check_eq("tt_cleared", tt, 0);
        busy_cnt = 0;
        while (!done && edges < 400) begin
            if (busy) busy_cnt++;
            start = (edges == poke_at);
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        e = sb_q.pop_front();
        check_eq("done_latency", edges, e.lat);
        check_eq("busy_cycles", busy_cnt, 64);
        check_eq("tt_at_done", tt, e.tt);
        check_eq("busy_at_done", busy, 0);
`ifdef PLA_TT_COMPARE_EN
        check_eq("mismatch", mismatch, (e.cnt != 0));
        check_eq("mism_cnt", mism_cnt, e.cnt);
        check_eq("first_mism", first_mism, e.first);
`endif
        start = poke_fin;
        @(negedge clk);
        start = 1'b0;
        check_eq("done_pulse_width", done, 0);
        check_eq("busy_after_fin", busy, 0);
        check_eq("x_out_after_fin", x_out, 0);
        repeat (2) @(negedge clk);
        check_eq("tt_held_idle", tt, e.tt);
    endtask

    initial begin
        int edges;
        int run;
        int done_seen;
        logic [5:0] prev_x;
        exp_t e;

        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; fn_sel = 0;
`ifdef PLA_TT_COMPARE_EN
        tt_ref = '0; tt_ref2 = '0;
`endif
        repeat (2) @(negedge clk);
        check_eq("rst_x_out", x_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_tt", tt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        sweep0(0, 64'h0, 64'h0, 7'd0, 6'd0, -1, 1'b0);
        sweep0(1, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 7'd0, 6'd0, 10, 1'b1);
        sweep0(2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 7'd0, 6'd0, -1, 1'b0);
`ifdef PLA_TT_COMPARE_EN
        sweep0(1, 64'hAAAA_AAAA_AAAA_AAAA,
               64'hAAAA_AAAA_AAAA_AAAA ^ 64'h0000_0100_0000_0020, 7'd2, 6'd5, -1, 1'b0);
`endif

        // Abort a sweep with reset at sweep cycle 30.
        fn_sel = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        while (edges < 30) begin
            @(negedge clk);
            edges++;
        end
        check_eq("pre_abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_x_out", x_out, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_tt", tt, 0);
`ifdef PLA_TT_COMPARE_EN
        check_eq("abort_mism_cnt", mism_cnt, 0);
        check_eq("abort_first_mism", first_mism, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check_eq("no_done_after_abort", done_seen, 0);

        sweep0(1, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 7'd0, 6'd0, -1, 1'b0);

        // SETTLE=2 instance with a two-cycle registered function path.
        e.tt = 64'hFFFF_FFFF_0000_0000; e.lat = 193; e.cnt = 7'd0; e.first = 6'd0;
        sb_q.push_back(e);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        edges  = 1;
        prev_x = x_out2;
        run    = 1;
        check_eq("s2_first_x", x_out2, 0);
        while (!done2 && edges < 1000) begin
            @(negedge clk);
            edges++;
            if (!done2) begin
                if (x_out2 != prev_x) begin
                    check_eq("s2_hold_len", run, 3);
                    run    = 1;
                    prev_x = x_out2;
                end else begin
                    run++;
                end
            end
        end
        e = sb_q.pop_front();
        check_eq("s2_last_hold_len", run, 3);
        check_eq("s2_done_latency", edges, e.lat);
        check_eq("s2_tt", tt2, e.tt);
        @(negedge clk);
        check_eq("s2_done_pulse_width", done2, 0);

        check_eq("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
